sram_mem_stage: RTL and testbench



---
 rtl/sram_mem_stage_pkg.sv | 24 ++
 rtl/sram_wait_counter.sv | 29 ++
 rtl/sram_mem_stage.sv | 139 +++++++++++++
 tb/tb_sram_mem_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_stage_pkg.sv
// Shared types and defaults for the SRAM memory-access stage.
package sram_mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_WAIT_CYCLES = 2;
  localparam int          DEF_SRAM_AW     = 18;

  // Halfword select: appended as the SRAM address LSB.
  localparam logic HW_LO = 1'b0;
  localparam logic HW_HI = 1'b1;

  function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-halfword wait counter: clear, increment, terminal flag at WAIT_CYCLES-1.
// Zero latency on tc; no backpressure.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_stage.sv
// 32-bit load/store stage over a 16-bit async SRAM as two halfword accesses.
// Result after 2*WAIT_CYCLES+1 cycles; ready low freezes upstream meanwhile.
module sram_mem_stage
  import sram_mem_stage_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int          SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int WA = SRAM_AW - 1;

  state_t        state, state_nxt;
  logic          req;
  logic          tc, cnt_clr, cnt_inc;
  logic [31:0]   offset;
  logic [WA-1:0] word_in, word_q;
  logic [31:0]   data_q;
  logic          wr_q;
  logic [15:0]   rdata_lo;
  logic          unused_offset_bits;

  assign req     = mem_read_en | mem_write_en;
  assign offset  = byte_offset(address, BASE_ADDR);
  assign word_in = offset[SRAM_AW:2];
  assign ready   = ~req | (state == DONE);

  // Byte lane and out-of-range bits are dropped, so addresses wrap silently.
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (req) state_nxt = LOW;
      end
      LOW: begin
        if (tc) begin
          cnt_clr   = 1'b1;
          state_nxt = HIGH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HIGH: begin
        if (tc) begin
          cnt_clr   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pins are registered on the edge entering each phase, so address,
  // data and strobe change together and stay put for the whole wait window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      rdata_lo    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            word_q      <= word_in;
            data_q      <= write_data;
            wr_q        <= mem_write_en;
            sram_addr   <= {word_in, HW_LO};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= mem_write_en;
            sram_we_n   <= ~mem_write_en;
          end
        end
        LOW: begin
          if (tc) begin
            if (!wr_q) rdata_lo <= sram_dq_in;
            sram_addr   <= {word_q, HW_HI};
            sram_dq_out <= data_q[31:16];
          end
        end
        HIGH: begin
          if (tc) begin
            if (!wr_q) read_data <= {sram_dq_in, rdata_lo};
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Scoreboard bench for sram_mem_stage against a behavioural 16-bit async SRAM.
module tb_sram_mem_stage;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic [15:0] sram_m [0:63] = '{2: 16'hBABE, 3: 16'hCAFE, default: 16'h0000};

  typedef struct {
    logic [31:0] data;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [31:0] last_rd = 32'h0;

  sram_mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_in   (sram_dq_in),
    .sram_dq_oe   (sram_dq_oe),
    .sram_we_n    (sram_we_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq_in = sram_m[sram_addr[5:0]];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_m[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every completed access must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (mem_read_en || mem_write_en) && ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: completion with empty scoreboard (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", cyc, mon_e.done_cyc);
        chk("read_data", read_data, mon_e.data);
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic [17:0] hw);
    exp_t e;
    int   c;
    bit   done;
    @(posedge clk); #1;
    mem_read_en  = rd;
    mem_write_en = wr;
    address      = a;
    write_data   = d;
    e.data       = wr ? last_rd : exp_rd;
    e.done_cyc   = cyc + 2 * W + 1;
    exp_q.push_back(e);
    if (!wr) last_rd = exp_rd;
    c    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (c >= 1 && c <= 2 * W) begin
        chk("hw_addr", sram_addr, (c <= W) ? hw : (hw | 18'd1));
        chk("we_n", sram_we_n, !wr);
        chk("dq_oe", sram_dq_oe, wr);
        if (wr) chk("dq_out", sram_dq_out, (c <= W) ? d[15:0] : d[31:16]);
      end
      if (ready) begin
        done = 1'b1;
      end else begin
        c++;
        if (c > 20) begin
          tests++;
          fails++;
          $display("FAIL ready_timeout: ready=0 after %0d cycles, expected 1 by %0d", c, 2 * W + 1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", ready, 1'b1);
      chk("idle_we_n", sram_we_n, 1'b1);
      chk("idle_oe", sram_dq_oe, 1'b0);
      chk("idle_read_data", read_data, last_rd);
    end
  endtask

  initial begin
    rst          = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;

    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_oe", sram_dq_oe, 1'b0);
    chk("rst_addr", sram_addr, 18'd0);
    chk("rst_dq_out", sram_dq_out, 16'h0);
    chk("rst_read_data", read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    idle(3);
    access(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'h0, 18'd0);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hCAFEBABE, 18'd2);
    idle(2);

    // Both enables high: must behave as a store, then reload back-to-back.
    access(1'b1, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0, 18'd4);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 18'd4);
    idle(2);

    // Reset asserted in the middle of the high-halfword write.
    @(posedge clk); #1;
    mem_write_en = 1'b1;
    address      = 32'd1036;
    write_data   = 32'h0BADF00D;
    repeat (2 * W - 1) @(posedge clk);
    #3;
    chk("mid_we_n", sram_we_n, 1'b0);
    chk("mid_addr", sram_addr, 18'd7);
    rst = 1'b0;
    #1;
    chk("arst_we_n", sram_we_n, 1'b1);
    chk("arst_oe", sram_dq_oe, 1'b0);
    chk("arst_addr", sram_addr, 18'd0);
    chk("arst_dq_out", sram_dq_out, 16'h0);
    chk("arst_read_data", read_data, 32'h0);
    last_rd      = 32'h0;
    mem_write_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_we_n", sram_we_n, 1'b1);

    // Address wrap: 1024 + 4*2^17 lands on halfwords 0 and 1.
    access(1'b1, 1'b0, 32'd1024 + 32'd524288, 32'h0, 32'h12345678, 18'd0);
    idle(2);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
